v3a_shift_queue_ctrl: RTL and testbench

- Multi-queue shifting buffer built from a linear array of p_depth entry registers. Each entry holds {ptr, data} plus an occupancy bit.
- Entries are appended at the tail. A dequeue removes the oldest entry whose ptr tag matches the requested queue ID, then compacts all younger entries forward by one slot.
- Sits between the op-issue front end (enqueue side) and per-queue consumers (dequeue side). It generates per-slot write, shift and occupancy controls for its internal storage array.

---
 rtl/v3a_shift_queue_ctrl.sv | 141 ++++++++++++++
 tb/tb_v3a_shift_queue_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/v3a_shift_queue_ctrl.sv
// Multi-queue shifting buffer: tail append, oldest-matching-tag dequeue with
// forward compaction of all younger entries.

module v3a_shift_queue_slot #(
    parameter int p_ptrwidth  = 5,
    parameter int p_chanwidth = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr,
    input  logic [1:0]             shift,
    input  logic [p_ptrwidth-1:0]  wr_ptr,
    input  logic [p_chanwidth-1:0] wr_data,
    input  logic [p_ptrwidth-1:0]  nxt_ptr,
    input  logic [p_chanwidth-1:0] nxt_data,
    input  logic                   nxt_occ,
    output logic [p_ptrwidth-1:0]  ptr,
    output logic [p_chanwidth-1:0] data,
    output logic                   occ
);
    localparam logic [1:0] SH_FWD = 2'b01;

    // A tail write beats the forward load so a same-cycle enq lands in the
    // slot vacated by compaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr  <= '0;
            data <= '0;
            occ  <= 1'b0;
        end else if (flush) begin
            occ  <= 1'b0;
        end else if (wr) begin
            ptr  <= wr_ptr;
            data <= wr_data;
            occ  <= 1'b1;
        end else if (shift == SH_FWD) begin
            ptr  <= nxt_ptr;
            data <= nxt_data;
            occ  <= nxt_occ;
        end
    end
endmodule

module v3a_shift_queue_ctrl #(
    parameter int p_depth     = 8,
    parameter int p_ptrwidth  = 5,
    parameter int p_chanwidth = 32,
    parameter int p_cntwidth  = $clog2(p_depth + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   enq_val,
    output logic                   enq_rdy,
    input  logic [p_ptrwidth-1:0]  enq_ptr,
    input  logic [p_chanwidth-1:0] enq_data,
    input  logic                   deq_req,
    input  logic [p_ptrwidth-1:0]  deq_ptr,
    output logic                   deq_val,
    output logic [p_chanwidth-1:0] deq_data,
    output logic [p_cntwidth-1:0]  count,
    output logic                   full,
    output logic                   empty
);
    localparam int p_idxw = $clog2(p_depth);
    // REV (2'b10) exists in the slot encoding but is never generated here.
    localparam logic [1:0] SH_IDLE = 2'b00;
    localparam logic [1:0] SH_FWD  = 2'b01;

    logic [p_depth-1:0][p_ptrwidth-1:0]  ptr_q, nxt_ptr;
    logic [p_depth-1:0][p_chanwidth-1:0] data_q, nxt_data;
    logic [p_depth-1:0]                  occ_q, nxt_occ, match, wr;
    logic [p_depth-1:0][1:0]             shift;
    logic [p_cntwidth-1:0]               count_q;
    logic [p_idxw-1:0]                   k;
    logic                                deq_fire, enq_fire;

    assign count    = count_q;
    assign full     = (count_q == p_cntwidth'(p_depth));
    assign empty    = (count_q == '0);
    assign enq_rdy  = !full;
    assign deq_val  = deq_req && (|match);
    assign deq_fire = deq_val;
    assign enq_fire = enq_val && enq_rdy;

    // Descending scan so the lowest (oldest) matching slot wins.
    always_comb begin
        k        = '0;
        deq_data = '0;
        for (int i = p_depth - 1; i >= 0; i--)
            if (match[i]) k = p_idxw'(i);
        if (deq_val) deq_data = data_q[k];
    end

    for (genvar i = 0; i < p_depth; i++) begin : g_slot
        if (i == p_depth - 1) begin : g_last
            assign nxt_ptr[i]  = '0;
            assign nxt_data[i] = '0;
            assign nxt_occ[i]  = 1'b0;
        end else begin : g_mid
            assign nxt_ptr[i]  = ptr_q[i+1];
            assign nxt_data[i] = data_q[i+1];
            assign nxt_occ[i]  = occ_q[i+1];
        end

        assign match[i] = occ_q[i] && (ptr_q[i] == deq_ptr);
        assign shift[i] = (deq_fire && (p_idxw'(i) >= k)) ? SH_FWD : SH_IDLE;
        // Tail is slot count, or count-1 once the dequeue has compacted.
        assign wr[i]    = enq_fire &&
                          (count_q == (deq_fire ? p_cntwidth'(i + 1) : p_cntwidth'(i)));

        v3a_shift_queue_slot #(
            .p_ptrwidth (p_ptrwidth),
            .p_chanwidth(p_chanwidth)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .wr      (wr[i]),
            .shift   (shift[i]),
            .wr_ptr  (enq_ptr),
            .wr_data (enq_data),
            .nxt_ptr (nxt_ptr[i]),
            .nxt_data(nxt_data[i]),
            .nxt_occ (nxt_occ[i]),
            .ptr     (ptr_q[i]),
            .data    (data_q[i]),
            .occ     (occ_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || flush)
            count_q <= '0;
        else if (enq_fire && !deq_fire)
            count_q <= count_q + 1'b1;
        else if (deq_fire && !enq_fire)
            count_q <= count_q - 1'b1;
    end
endmodule

// File: tb/tb_v3a_shift_queue_ctrl.sv
// Randomized + directed bench for v3a_shift_queue_ctrl against a queue-based
// reference model of the tagged shifting buffer.

module tb_v3a_shift_queue_ctrl;
    localparam int DEPTH = 8;

    typedef struct {
        logic [4:0]  ptr;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, enq_val, enq_rdy, deq_req, deq_val, full, empty;
    logic [4:0]  enq_ptr, deq_ptr;
    logic [31:0] enq_data, deq_data;
    logic [3:0]  count;

    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];

    always #5 clk = ~clk;

    v3a_shift_queue_ctrl #(
        .p_depth    (DEPTH),
        .p_ptrwidth (5),
        .p_chanwidth(32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .enq_val (enq_val),
        .enq_rdy (enq_rdy),
        .enq_ptr (enq_ptr),
        .enq_data(enq_data),
        .deq_req (deq_req),
        .deq_ptr (deq_ptr),
        .deq_val (deq_val),
        .deq_data(deq_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, check outputs against the model mid-cycle,
    // then advance the model by what the coming edge should do.
    task automatic step(input logic r, input logic f, input logic ev, input logic [4:0] ep,
                        input logic [31:0] ed, input logic dr, input logic [4:0] dp);
        int          sz;
        int          hit;
        logic        e_val;
        logic [31:0] e_data;
        ent_t        ne;
        @(posedge clk);
        #1;
        rst = r; flush = f; enq_val = ev; enq_ptr = ep; enq_data = ed;
        deq_req = dr; deq_ptr = dp;
        #4;
        sz  = mq.size();
        hit = -1;
        for (int i = 0; i < sz; i++)
            if (hit < 0 && mq[i].ptr == dp) hit = i;
        e_val  = dr && (hit >= 0);
        e_data = e_val ? mq[hit].data : 32'h0;
        chk("count", 32'(count), 32'(sz));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("enq_rdy", 32'(enq_rdy), 32'(sz != DEPTH));
        chk("deq_val", 32'(deq_val), 32'(e_val));
        chk("deq_data", deq_data, e_data);
        if (r || f) begin
            mq.delete();
        end else begin
            if (e_val) mq.delete(hit);
            if (ev && sz < DEPTH) begin
                ne.ptr = ep; ne.data = ed;
                mq.push_back(ne);
            end
        end
    endtask

    task automatic enq(input logic [4:0] p, input logic [31:0] d);
        step(1'b0, 1'b0, 1'b1, p, d, 1'b0, 5'd0);
    endtask

    task automatic deq(input logic [4:0] p);
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, p);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; enq_val = 1'b0; enq_ptr = '0; enq_data = '0;
        deq_req = 1'b0; deq_ptr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, lookup with no entries
        deq(5'd3);
        chk("rst_dv", 32'(deq_val), 32'h0);

        // FIFO order within one ID
        enq(5'd2, 32'hA0); enq(5'd2, 32'hA1); enq(5'd2, 32'hA2);
        deq(5'd2); chk("fifo0", deq_data, 32'hA0);
        deq(5'd2); chk("fifo1", deq_data, 32'hA1);
        deq(5'd2); chk("fifo2", deq_data, 32'hA2);
        idle();    chk("fifo_empty", 32'(empty), 32'h1);

        // Middle removal compacts younger entries
        enq(5'd1, 32'h11); enq(5'd2, 32'h21); enq(5'd1, 32'h12); enq(5'd3, 32'h31);
        deq(5'd2); chk("mid_21", deq_data, 32'h21);
        deq(5'd1); chk("mid_11", deq_data, 32'h11);
        chk("mid_cnt", 32'(count), 32'h3);
        deq(5'd1); chk("mid_12", deq_data, 32'h12);
        deq(5'd3); chk("mid_31", deq_data, 32'h31);

        // Full boundary: no enq bypass even when a dequeue fires
        for (int i = 0; i < DEPTH; i++) enq(5'(i), 32'h100 + 32'(i));
        step(1'b0, 1'b0, 1'b1, 5'd9, 32'h999, 1'b1, 5'd4);
        chk("full_flag", 32'(full), 32'h1);
        chk("full_deq", deq_data, 32'h104);
        step(1'b0, 1'b0, 1'b1, 5'd9, 32'h999, 1'b0, 5'd0);
        chk("full_cnt7", 32'(count), 32'h7);
        chk("full_rdy", 32'(enq_rdy), 32'h1);
        deq(5'd9); chk("full_new", deq_data, 32'h999);
        step(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

        // Simultaneous enq/deq
        enq(5'd5, 32'h50); enq(5'd6, 32'h60);
        step(1'b0, 1'b0, 1'b1, 5'd7, 32'h70, 1'b1, 5'd5);
        chk("sim_50", deq_data, 32'h50);
        deq(5'd6); chk("sim_cnt", 32'(count), 32'h2);
        chk("sim_60", deq_data, 32'h60);
        deq(5'd7); chk("sim_70", deq_data, 32'h70);

        // Miss, flush with enq, reset during dequeue
        enq(5'd1, 32'h77);
        deq(5'd9); chk("miss_dv", 32'(deq_val), 32'h0);
        step(1'b0, 1'b1, 1'b1, 5'd1, 32'h88, 1'b0, 5'd0);
        idle(); chk("flush_cnt", 32'(count), 32'h0);
        enq(5'd4, 32'h44);
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
        chk("rst_deq", deq_data, 32'h44);
        idle(); chk("rst_cnt", 32'(count), 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 47) == 0,
                 $urandom_range(0, 9) < 6, 5'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 4)));
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
